snoop_coordinator: RTL and testbench
====================================

Name: snoop_coordinator

Overview:
- Bus-side stage directly upstream of every per-cache snoop_controller.
- Takes the arbiter's winning request and broadcasts it to all non-requesting caches (sb_valid/sb_tx_begin/pkt).
- Collects their wait/hit/data responses and returns a single coherence response to the requester.
- Forwards modified-block data beats both to the requester and to the main-memory writeback port.

Parameters:
- num_caches_p, 4: number of snooping caches; minimum 2.
- dma_data_width_p, 2: 32-bit words per bus beat.
- block_words_p, 8: words per cache block. Must be a multiple of dma_data_width_p. beats_lp = block_words_p/dma_data_width_p.
- timeout_p, 256: wait-cycle limit; used only with SNOOP_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- nreset_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  arbiter has a winning request
- req_id_i  in  $clog2(num_caches_p)  requester index
- req_pkt_i  in  cache_bus_pkt_width  request packet
- req_ready_o  out  1  request accepted this cycle (only in s_idle)
- sb_valid_o  out  num_caches_p  per-cache snoop valid; requester bit always 0
- sb_tx_begin_o  out  1  first cycle of a broadcast
- sb_last_rx_o  out  num_caches_p  owner's final beat is expected
- sb_bus_pkt_o  out  cache_bus_pkt_width  broadcast packet; addr auto-increments per beat
- sb_wait_i, sb_hit_i, sb_valid_i  in  num_caches_p each  per-cache snoop responses
- sb_data_i  in  num_caches_p*dma_data_width_p*32  per-cache data; zero when that cache's valid is low
- resp_valid_o  out  1  one-cycle pulse: snoop complete
- resp_shared_o  out  1  any cache hit (valid with resp_valid_o)
- resp_dirty_o  out  1  block was supplied by a cache, not memory
- resp_data_valid_o  out  1  forwarded beat valid
- resp_data_o  out  dma_data_width_p*32  forwarded beat
- mem_wb_valid_o  out  1  writeback beat valid; no backpressure
- mem_wb_addr_o  out  32  beat address
- mem_wb_data_o  out  dma_data_width_p*32  beat data
- snoop_err_o  out  1  sticky error flag

Behaviour:
- Reset: all state returns to s_idle asynchronously. beat counter = 0, pkt register = 0. Every output is 0 except req_ready_o, which is 1 because it is a combinational function of s_idle. Reset mid-transaction abandons the transaction; no resp_valid_o is produced.
- States: s_idle, s_check, s_wait, s_data.
- s_idle:
  - req_ready_o = 1.
  - On req_valid_i: latch req_pkt_i and req_id_i, go to s_check.
  - In that same cycle, drive sb_tx_begin_o = 1 and sb_valid_o = all-ones with bit req_id cleared, using the incoming pkt. Broadcast latency is 0 cycles.
- s_check (cycle T+1):
  - sb_valid_o is held, sb_tx_begin_o = 0. Sample hit_any = |(sb_hit_i & sb_valid_o) into a register.
  - If no enabled cache asserts sb_wait_i: pulse resp_valid_o with resp_dirty_o = 0 and go to s_idle.
  - Else go to s_wait.
- s_wait:
  - The first cycle any enabled sb_valid_i is seen: record the owner one-hot, go to s_data, and process that cycle as beat 0.
  - If all waits drop and no data has been seen: pulse resp_valid_o with resp_dirty_o = 0 and go to s_idle.
- s_data:
  - Each cycle the owner's sb_valid_i is high:
    - resp_data_valid_o = mem_wb_valid_o = 1.
    - Data comes from the owner; mem_wb_addr_o = current pkt addr.
    - Pkt addr += dma_data_width_p*4; beat counter += 1.
  - sb_last_rx_o[owner] = 1 while the beat counter == beats_lp-1.
  - On the last beat: pulse resp_valid_o with resp_dirty_o = 1 on the following cycle, clear the counter, go to s_idle.
- Bubbles: gaps in the owner's sb_valid_i are allowed; the counter simply holds.
- resp_shared_o = hit_any register (it includes the owner).
- Invalid response combinations (any is fatal; set snoop_err_o, which holds until reset):
  - more than one enabled cache asserting sb_valid_i in a cycle;
  - a non-owner asserting sb_valid_i;
  - sb_valid_i asserted outside s_wait/s_data;
  - the requester's own response bits, which are masked everywhere.
- Back-to-back: after s_idle is re-entered, a new request is accepted on the very next cycle.

Optional Feature:
- Macro SNOOP_TIMEOUT_EN.
- Defined:
  - A counter runs in s_wait/s_data and clears whenever a state transition or beat occurs.
  - When it reaches timeout_p: set snoop_err_o, pulse resp_valid_o with resp_dirty_o = 0, go to s_idle.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Shared cache package / cache.vh: bus_req_type_t, block_state_t, cache_bus_pkt macros, the coordinator state enum, and the addr-increment constant.
- One sub-module, snoop_resp_mux: takes the valid mask and per-cache vectors; produces hit_any, wait_any, data_any, the owner one-hot, multi-owner error, and OR-reduced data.

Test Plan:
- No hits: 4 caches, req_id=0 issues a load at addr 0x100. All sb_hit/sb_wait are 0 at T+1 -> resp_valid_o at T+1, shared=0, dirty=0, req_ready_o=1 at T+2.
- Shared hit: cache 2 hits with wait=0 -> resp_valid_o at T+1 with shared=1, dirty=0, and sb_valid_o = 4'b1110 during T to T+1.
- Exclusive set-state stall: cache 3 holds wait for 5 cycles with no data -> resp_valid_o on the first cycle after wait drops; no mem_wb beats.
- Modified writeback, 4 beats at addr 0x200 from cache 1, with a 1-cycle bubble after beat 1 -> mem_wb_addr_o = 0x200, 0x208, 0x210, 0x218. sb_last_rx_o = 4'b0010 only during beat 3. dirty=1.
- Two caches assert sb_valid_i in the same cycle -> snoop_err_o = 1 and stays set. Assert nreset_i low mid-s_data -> all outputs 0 immediately, next request accepted after release.
- With SNOOP_TIMEOUT_EN and timeout_p = 16: wait is held forever -> after 16 wait cycles snoop_err_o = 1, resp_valid_o pulses, and the block returns to s_idle.

Source files
------------

// File: rtl/snoop_coordinator_pkg.sv
// ---------------------------------------------------------------------------
// snoop_coordinator_pkg
//   Shared cache-coherence types for the snoop bus: bus request kinds, MESI
//   block states, the broadcast packet layout, the coordinator FSM encoding
//   and the per-beat address increment helper.
//   Optional feature macro used by the coordinator: SNOOP_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package snoop_coordinator_pkg;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_type_t;

    typedef enum logic [1:0] {
        BLK_I = 2'd0,
        BLK_S = 2'd1,
        BLK_E = 2'd2,
        BLK_M = 2'd3
    } block_state_t;

    // Broadcast packet: block/beat byte address in the upper bits, request kind below.
    typedef struct packed {
        logic [31:0]   addr;
        bus_req_type_t req_type;
    } cache_bus_pkt_t;

    localparam int cache_bus_pkt_width = $bits(cache_bus_pkt_t);

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_check = 2'd1,
        s_wait  = 2'd2,
        s_data  = 2'd3
    } coord_state_t;

    localparam int word_bytes_lp = 4;

    // Byte distance between consecutive data beats.
    function automatic logic [31:0] beat_addr_incr(input int dma_words);
        return 32'(dma_words * word_bytes_lp);
    endfunction

endpackage

// File: rtl/snoop_resp_mux.sv
// ---------------------------------------------------------------------------
// snoop_resp_mux
//   Reduces the per-cache snoop responses under an enable mask.
//   Ports:
//     mask_i        enabled caches (requester and, during data, non-owners cleared)
//     hit_i/wait_i/valid_i  per-cache response bits
//     data_i        per-cache data beats, cache i at [i*data_width_p +: data_width_p]
//     hit_any_o, wait_any_o, data_any_o  OR of the masked vectors
//     owner_oh_o    masked valid vector (one-hot when well formed)
//     multi_err_o   more than one enabled cache drove data
//     data_o        OR of the data of every enabled, valid cache
// ---------------------------------------------------------------------------
module snoop_resp_mux #(
    parameter int num_caches_p = 4,
    parameter int data_width_p = 64
) (
    input  logic [num_caches_p-1:0]              mask_i,
    input  logic [num_caches_p-1:0]              hit_i,
    input  logic [num_caches_p-1:0]              wait_i,
    input  logic [num_caches_p-1:0]              valid_i,
    input  logic [num_caches_p*data_width_p-1:0] data_i,
    output logic                                 hit_any_o,
    output logic                                 wait_any_o,
    output logic                                 data_any_o,
    output logic [num_caches_p-1:0]              owner_oh_o,
    output logic                                 multi_err_o,
    output logic [data_width_p-1:0]              data_o
);

    logic [num_caches_p-1:0] valid_m;

    assign valid_m     = valid_i & mask_i;
    assign hit_any_o   = |(hit_i & mask_i);
    assign wait_any_o  = |(wait_i & mask_i);
    assign data_any_o  = |valid_m;
    assign owner_oh_o  = valid_m;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_err_o = |(valid_m & (valid_m - num_caches_p'(1)));

    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // update, so no path leaves it unassigned and no latch is inferred.
        data_o = '0;
        for (int i = 0; i < num_caches_p; i++) begin
            if (valid_m[i]) begin
                data_o = data_o | data_i[i*data_width_p +: data_width_p];
            end
        end
    end

endmodule

// File: rtl/snoop_coordinator.sv
// ---------------------------------------------------------------------------
// snoop_coordinator
//   Broadcasts the arbiter's winning request to every non-requesting cache,
//   merges the wait/hit/data responses into one coherence response, and
//   forwards dirty-block beats to the requester and the memory writeback port.
//   Optional feature: define SNOOP_TIMEOUT_EN to abort a snoop whose wait or
//   data phase stalls for timeout_p cycles (sets snoop_err_o).
//   Ports:
//     clk_i, nreset_i                 clock, asynchronous active-low reset
//     req_valid_i/req_id_i/req_pkt_i  winning request; req_ready_o in s_idle
//     sb_valid_o/sb_tx_begin_o/sb_last_rx_o/sb_bus_pkt_o  broadcast side
//     sb_wait_i/sb_hit_i/sb_valid_i/sb_data_i             per-cache responses
//     resp_*_o                        merged response and forwarded beats
//     mem_wb_*_o                      writeback beats (no backpressure)
//     snoop_err_o                     sticky protocol-error flag
// ---------------------------------------------------------------------------
module snoop_coordinator
    import snoop_coordinator_pkg::*;
#(
    parameter int num_caches_p     = 4,
    parameter int dma_data_width_p = 2,
    parameter int block_words_p    = 8,
    parameter int timeout_p        = 256
) (
    input  logic                                       clk_i,
    input  logic                                       nreset_i,
    input  logic                                       req_valid_i,
    input  logic [$clog2(num_caches_p)-1:0]            req_id_i,
    input  logic [cache_bus_pkt_width-1:0]             req_pkt_i,
    output logic                                       req_ready_o,
    output logic [num_caches_p-1:0]                    sb_valid_o,
    output logic                                       sb_tx_begin_o,
    output logic [num_caches_p-1:0]                    sb_last_rx_o,
    output logic [cache_bus_pkt_width-1:0]             sb_bus_pkt_o,
    input  logic [num_caches_p-1:0]                    sb_wait_i,
    input  logic [num_caches_p-1:0]                    sb_hit_i,
    input  logic [num_caches_p-1:0]                    sb_valid_i,
    input  logic [num_caches_p*dma_data_width_p*32-1:0] sb_data_i,
    output logic                                       resp_valid_o,
    output logic                                       resp_shared_o,
    output logic                                       resp_dirty_o,
    output logic                                       resp_data_valid_o,
    output logic [dma_data_width_p*32-1:0]             resp_data_o,
    output logic                                       mem_wb_valid_o,
    output logic [31:0]                                mem_wb_addr_o,
    output logic [dma_data_width_p*32-1:0]             mem_wb_data_o,
    output logic                                       snoop_err_o
);

    localparam int                  beat_w_lp    = dma_data_width_p * 32;
    localparam int                  beats_lp     = block_words_p / dma_data_width_p;
    localparam int                  cnt_w_lp     = $clog2(beats_lp) + 1;
    localparam logic [31:0]         addr_incr_lp = beat_addr_incr(dma_data_width_p);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp  = cnt_w_lp'(beats_lp - 1);

    coord_state_t                  state_r, state_n;
    cache_bus_pkt_t                pkt_r;
    logic [$clog2(num_caches_p)-1:0] req_id_r;
    logic [num_caches_p-1:0]       owner_r;
    logic [cnt_w_lp-1:0]           beat_cnt_r;
    logic                          hit_any_r;
    logic                          dirty_resp_r;
    logic                          err_r;

    logic [num_caches_p-1:0] req_mask_r;
    logic [num_caches_p-1:0] mux_mask;
    logic                    hit_any, wait_any, data_any, multi_err;
    logic [num_caches_p-1:0] owner_oh;
    logic [beat_w_lp-1:0]    data_or;
    logic                    clean_resp, beat, last_beat, err_set, tmo_hit;

    // Responders never include the requester.
    assign req_mask_r = ~(num_caches_p'(1) << req_id_r);
    // Once an owner is chosen only its beats are forwarded.
    assign mux_mask   = (state_r == s_data) ? owner_r : req_mask_r;

    snoop_resp_mux #(
        .num_caches_p (num_caches_p),
        .data_width_p (beat_w_lp)
    ) u_resp_mux (
        .mask_i      (mux_mask),
        .hit_i       (sb_hit_i),
        .wait_i      (sb_wait_i),
        .valid_i     (sb_valid_i),
        .data_i      (sb_data_i),
        .hit_any_o   (hit_any),
        .wait_any_o  (wait_any),
        .data_any_o  (data_any),
        .owner_oh_o  (owner_oh),
        .multi_err_o (multi_err),
        .data_o      (data_or)
    );

`ifdef SNOOP_TIMEOUT_EN
    localparam int tmo_w_lp = $clog2(timeout_p + 1);
    logic [tmo_w_lp-1:0] tmo_cnt_r;

    assign tmo_hit = ((state_r == s_wait) || (state_r == s_data)) &&
                     (tmo_cnt_r == tmo_w_lp'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            tmo_cnt_r <= '0;
        end else if ((state_n != state_r) || beat) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == s_wait) || (state_r == s_data)) begin
            tmo_cnt_r <= tmo_cnt_r + tmo_w_lp'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_p > 0);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_n       = state_r;
        req_ready_o   = 1'b0;
        sb_tx_begin_o = 1'b0;
        sb_valid_o    = '0;
        sb_bus_pkt_o  = pkt_r;
        clean_resp    = 1'b0;
        beat          = 1'b0;
        err_set       = 1'b0;
        unique case (state_r)
            s_idle: begin
                req_ready_o  = 1'b1;
                sb_bus_pkt_o = '0;
                // No transaction is open, so any data (outside the new requester's own) is illegal.
                err_set = |(sb_valid_i & (req_valid_i ? ~(num_caches_p'(1) << req_id_i) : '1));
                if (req_valid_i) begin
                    sb_tx_begin_o = 1'b1;
                    sb_valid_o    = ~(num_caches_p'(1) << req_id_i);
                    sb_bus_pkt_o  = req_pkt_i;
                    state_n       = s_check;
                end
            end
            s_check: begin
                sb_valid_o = req_mask_r;
                err_set    = data_any;
                if (!wait_any) begin
                    clean_resp = 1'b1;
                    state_n    = s_idle;
                end else begin
                    state_n = s_wait;
                end
            end
            s_wait: begin
                sb_valid_o = req_mask_r;
                err_set    = multi_err;
                if (data_any) begin
                    beat    = 1'b1;
                    state_n = s_data;
                end else if (!wait_any) begin
                    clean_resp = 1'b1;
                    state_n    = s_idle;
                end
            end
            s_data: begin
                sb_valid_o = req_mask_r;
                err_set    = |(sb_valid_i & req_mask_r & ~owner_r);
                beat       = data_any;
            end
            default: state_n = s_idle;
        endcase

        last_beat = beat && (beat_cnt_r == last_cnt_lp);
        if (last_beat) begin
            state_n = s_idle;
        end
        if (tmo_hit && !beat && (state_n == state_r)) begin
            state_n    = s_idle;
            clean_resp = 1'b1;
            err_set    = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_r      <= s_idle;
            pkt_r        <= '0;
            req_id_r     <= '0;
            owner_r      <= '0;
            beat_cnt_r   <= '0;
            hit_any_r    <= 1'b0;
            dirty_resp_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_r      <= state_n;
            dirty_resp_r <= last_beat;
            err_r        <= err_r | err_set;
            if ((state_r == s_idle) && req_valid_i) begin
                pkt_r    <= req_pkt_i;
                req_id_r <= req_id_i;
            end
            if (state_r == s_check) begin
                hit_any_r <= hit_any;
            end
            if ((state_r == s_wait) && data_any) begin
                owner_r <= owner_oh;
            end
            if (beat) begin
                pkt_r.addr <= pkt_r.addr + addr_incr_lp;
            end
            if (state_n == s_idle) begin
                beat_cnt_r <= '0;
            end else if (beat) begin
                beat_cnt_r <= beat_cnt_r + cnt_w_lp'(1);
            end
        end
    end

    // The dirty response trails the last beat by one cycle; a clean one is immediate.
    assign resp_valid_o      = clean_resp | dirty_resp_r;
    assign resp_dirty_o      = dirty_resp_r;
    // In s_check the hit register is still being loaded, so bypass it.
    assign resp_shared_o     = resp_valid_o & ((state_r == s_check) ? hit_any : hit_any_r);
    assign resp_data_valid_o = beat;
    assign resp_data_o       = beat ? data_or : '0;
    assign mem_wb_valid_o    = beat;
    assign mem_wb_addr_o     = beat ? pkt_r.addr : '0;
    assign mem_wb_data_o     = beat ? data_or : '0;
    assign sb_last_rx_o      = ((state_r == s_data) && (beat_cnt_r == last_cnt_lp)) ? owner_r : '0;
    assign snoop_err_o       = err_r;

endmodule

// File: tb/tb_snoop_coordinator.sv
// ---------------------------------------------------------------------------
// tb_snoop_coordinator
//   Directed bench for snoop_coordinator with default parameters
//   (4 caches, 2 words per beat, 8 words per block -> 4 beats).
//   Inputs change 1 time unit after the rising edge; outputs are checked on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_snoop_coordinator;
    import snoop_coordinator_pkg::*;

    localparam int n_lp  = 4;
    localparam int bw_lp = 64;

    logic                          clk_i = 1'b0;
    logic                          nreset_i;
    logic                          req_valid_i;
    logic [1:0]                    req_id_i;
    cache_bus_pkt_t                req_pkt_i;
    logic                          req_ready_o;
    logic [n_lp-1:0]               sb_valid_o;
    logic                          sb_tx_begin_o;
    logic [n_lp-1:0]               sb_last_rx_o;
    logic [cache_bus_pkt_width-1:0] sb_bus_pkt_o;
    logic [n_lp-1:0]               sb_wait_i;
    logic [n_lp-1:0]               sb_hit_i;
    logic [n_lp-1:0]               sb_valid_i;
    logic [n_lp*bw_lp-1:0]         sb_data_i;
    logic                          resp_valid_o;
    logic                          resp_shared_o;
    logic                          resp_dirty_o;
    logic                          resp_data_valid_o;
    logic [bw_lp-1:0]              resp_data_o;
    logic                          mem_wb_valid_o;
    logic [31:0]                   mem_wb_addr_o;
    logic [bw_lp-1:0]              mem_wb_data_o;
    logic                          snoop_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    snoop_coordinator dut (
        .clk_i             (clk_i),
        .nreset_i          (nreset_i),
        .req_valid_i       (req_valid_i),
        .req_id_i          (req_id_i),
        .req_pkt_i         (req_pkt_i),
        .req_ready_o       (req_ready_o),
        .sb_valid_o        (sb_valid_o),
        .sb_tx_begin_o     (sb_tx_begin_o),
        .sb_last_rx_o      (sb_last_rx_o),
        .sb_bus_pkt_o      (sb_bus_pkt_o),
        .sb_wait_i         (sb_wait_i),
        .sb_hit_i          (sb_hit_i),
        .sb_valid_i        (sb_valid_i),
        .sb_data_i         (sb_data_i),
        .resp_valid_o      (resp_valid_o),
        .resp_shared_o     (resp_shared_o),
        .resp_dirty_o      (resp_dirty_o),
        .resp_data_valid_o (resp_data_valid_o),
        .resp_data_o       (resp_data_o),
        .mem_wb_valid_o    (mem_wb_valid_o),
        .mem_wb_addr_o     (mem_wb_addr_o),
        .mem_wb_data_o     (mem_wb_data_o),
        .snoop_err_o       (snoop_err_o)
    );

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] id, input logic [31:0] addr, input bus_req_type_t kind);
        req_valid_i        = 1'b1;
        req_id_i           = id;
        req_pkt_i.addr     = addr;
        req_pkt_i.req_type = kind;
    endtask

    task automatic test_reset();
        nreset_i    = 1'b0;
        req_valid_i = 1'b0;
        req_id_i    = '0;
        req_pkt_i   = '0;
        sb_wait_i   = '0;
        sb_hit_i    = '0;
        sb_valid_i  = '0;
        sb_data_i   = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
        checks++; if (sb_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_sb_valid got %b exp 0000", sb_valid_o); end
        checks++; if (sb_tx_begin_o !== 1'b0) begin errors++; $display("FAIL reset_tx_begin got %b exp 0", sb_tx_begin_o); end
        checks++; if (sb_bus_pkt_o !== '0) begin errors++; $display("FAIL reset_bus_pkt got %h exp 0", sb_bus_pkt_o); end
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid_o); end
        checks++; if (mem_wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_wb_valid got %b exp 0", mem_wb_valid_o); end
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", snoop_err_o); end
        nreset_i = 1'b1;
        next_cycle();
    endtask

    // Load at 0x100 from cache 0, nobody holds the line.
    task automatic test_no_hit();
        cache_bus_pkt_t exp_pkt;
        exp_pkt.addr = 32'h100;
        exp_pkt.req_type = BUS_RD;
        issue(2'd0, 32'h100, BUS_RD);
        @(negedge clk_i);
        checks++; if (sb_tx_begin_o !== 1'b1) begin errors++; $display("FAIL nohit_tx_begin got %b exp 1", sb_tx_begin_o); end
        checks++; if (sb_valid_o !== 4'b1110) begin errors++; $display("FAIL nohit_sb_valid got %b exp 1110", sb_valid_o); end
        checks++; if (sb_bus_pkt_o !== exp_pkt) begin errors++; $display("FAIL nohit_bus_pkt got %h exp %h", sb_bus_pkt_o, exp_pkt); end
        next_cycle();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL nohit_resp_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_shared_o !== 1'b0) begin errors++; $display("FAIL nohit_shared got %b exp 0", resp_shared_o); end
        checks++; if (resp_dirty_o !== 1'b0) begin errors++; $display("FAIL nohit_dirty got %b exp 0", resp_dirty_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL nohit_ready_busy got %b exp 0", req_ready_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL nohit_ready_t2 got %b exp 1", req_ready_o); end
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL nohit_resp_t2 got %b exp 0", resp_valid_o); end
        next_cycle();
    endtask

    // Cache 2 hits without waiting.
    task automatic test_shared_hit();
        issue(2'd0, 32'h140, BUS_RD);
        next_cycle();
        req_valid_i = 1'b0;
        sb_hit_i    = 4'b0100;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL shared_resp_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_shared_o !== 1'b1) begin errors++; $display("FAIL shared_shared got %b exp 1", resp_shared_o); end
        checks++; if (resp_dirty_o !== 1'b0) begin errors++; $display("FAIL shared_dirty got %b exp 0", resp_dirty_o); end
        checks++; if (sb_valid_o !== 4'b1110) begin errors++; $display("FAIL shared_sb_valid_t1 got %b exp 1110", sb_valid_o); end
        checks++; if (sb_tx_begin_o !== 1'b0) begin errors++; $display("FAIL shared_tx_begin_t1 got %b exp 0", sb_tx_begin_o); end
        next_cycle();
        sb_hit_i = '0;
    endtask

    // Requester 3's own hit/wait/valid bits are ignored.
    task automatic test_requester_mask();
        issue(2'd3, 32'h500, BUS_RDX);
        @(negedge clk_i);
        checks++; if (sb_valid_o !== 4'b0111) begin errors++; $display("FAIL mask_sb_valid got %b exp 0111", sb_valid_o); end
        next_cycle();
        req_valid_i = 1'b0;
        sb_hit_i    = 4'b1000;
        sb_wait_i   = 4'b1000;
        sb_valid_i  = 4'b1000;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL mask_resp_valid got %b exp 1", resp_valid_o); end
        checks++; if (resp_shared_o !== 1'b0) begin errors++; $display("FAIL mask_shared got %b exp 0", resp_shared_o); end
        next_cycle();
        sb_hit_i   = '0;
        sb_wait_i  = '0;
        sb_valid_i = '0;
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL mask_err got %b exp 0", snoop_err_o); end
        next_cycle();
    endtask

    // Cache 3 stalls five cycles with wait, then releases without data.
    task automatic test_stall();
        issue(2'd0, 32'h180, BUS_RDX);
        next_cycle();
        req_valid_i = 1'b0;
        sb_hit_i    = 4'b1000;
        sb_wait_i   = 4'b1000;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_resp_t1 got %b exp 0", resp_valid_o); end
        next_cycle();
        sb_hit_i = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_resp_wait%0d got %b exp 0", c, resp_valid_o); end
            checks++; if (mem_wb_valid_o !== 1'b0) begin errors++; $display("FAIL stall_wb_wait%0d got %b exp 0", c, mem_wb_valid_o); end
            next_cycle();
        end
        sb_wait_i = '0;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL stall_resp_release got %b exp 1", resp_valid_o); end
        checks++; if (resp_shared_o !== 1'b1) begin errors++; $display("FAIL stall_shared got %b exp 1", resp_shared_o); end
        checks++; if (resp_dirty_o !== 1'b0) begin errors++; $display("FAIL stall_dirty got %b exp 0", resp_dirty_o); end
        checks++; if (mem_wb_valid_o !== 1'b0) begin errors++; $display("FAIL stall_wb_release got %b exp 0", mem_wb_valid_o); end
        next_cycle();
    endtask

    // Cache 1 supplies a modified block at 0x200 with a bubble after beat 1.
    // Leaves the DUT in the idle cycle that carries the dirty response.
    task automatic test_writeback();
        logic [bw_lp-1:0] beat_data [4];
        logic             pattern   [5];
        int               bi;
        beat_data = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
                      64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
        pattern   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        issue(2'd0, 32'h200, BUS_RD);
        next_cycle();
        req_valid_i = 1'b0;
        sb_hit_i    = 4'b0010;
        sb_wait_i   = 4'b0010;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL wb_resp_t1 got %b exp 0", resp_valid_o); end
        next_cycle();
        sb_hit_i  = '0;
        sb_wait_i = '0;
        bi = 0;
        for (int c = 0; c < 5; c++) begin
            sb_valid_i = pattern[c] ? 4'b0010 : 4'b0000;
            sb_data_i  = '0;
            if (pattern[c]) sb_data_i[1*bw_lp +: bw_lp] = beat_data[bi];
            @(negedge clk_i);
            checks++; if (mem_wb_valid_o !== pattern[c]) begin errors++; $display("FAIL wb_valid_c%0d got %b exp %b", c, mem_wb_valid_o, pattern[c]); end
            checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL wb_resp_c%0d got %b exp 0", c, resp_valid_o); end
            checks++; if (sb_last_rx_o !== ((pattern[c] && bi == 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL wb_last_rx_c%0d got %b", c, sb_last_rx_o); end
            if (pattern[c]) begin
                checks++; if (mem_wb_addr_o !== 32'h200 + 32'(8 * bi)) begin errors++; $display("FAIL wb_addr_b%0d got %h exp %h", bi, mem_wb_addr_o, 32'h200 + 32'(8 * bi)); end
                checks++; if (mem_wb_data_o !== beat_data[bi]) begin errors++; $display("FAIL wb_data_b%0d got %h exp %h", bi, mem_wb_data_o, beat_data[bi]); end
                checks++; if (resp_data_o !== beat_data[bi] || resp_data_valid_o !== 1'b1) begin errors++; $display("FAIL wb_resp_data_b%0d got %h/%b exp %h/1", bi, resp_data_o, resp_data_valid_o, beat_data[bi]); end
                bi++;
            end
            next_cycle();
        end
        sb_valid_i = '0;
        sb_data_i  = '0;
    endtask

    // New request lands in the same idle cycle as the dirty response.
    task automatic test_back_to_back();
        issue(2'd2, 32'h300, BUS_RD);
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_dirty_resp got %b exp 1", resp_valid_o); end
        checks++; if (resp_dirty_o !== 1'b1) begin errors++; $display("FAIL b2b_dirty got %b exp 1", resp_dirty_o); end
        checks++; if (resp_shared_o !== 1'b1) begin errors++; $display("FAIL b2b_dirty_shared got %b exp 1", resp_shared_o); end
        checks++; if (sb_last_rx_o !== 4'b0000) begin errors++; $display("FAIL b2b_last_rx got %b exp 0000", sb_last_rx_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", req_ready_o); end
        checks++; if (sb_tx_begin_o !== 1'b1 || sb_valid_o !== 4'b1011) begin errors++; $display("FAIL b2b_broadcast got %b/%b exp 1/1011", sb_tx_begin_o, sb_valid_o); end
        next_cycle();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1 || resp_dirty_o !== 1'b0 || resp_shared_o !== 1'b0) begin errors++; $display("FAIL b2b_second_resp got v%b d%b s%b exp v1 d0 s0", resp_valid_o, resp_dirty_o, resp_shared_o); end
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", snoop_err_o); end
        next_cycle();
    endtask

    // Two caches drive data together; then reset lands mid-s_data.
    task automatic test_multi_owner_and_reset();
        issue(2'd0, 32'h400, BUS_RD);
        next_cycle();
        req_valid_i = 1'b0;
        sb_wait_i   = 4'b0110;
        next_cycle();
        sb_wait_i  = '0;
        sb_valid_i = 4'b0110;
        sb_data_i[1*bw_lp +: bw_lp] = 64'h1;
        sb_data_i[2*bw_lp +: bw_lp] = 64'h2;
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL multi_err_before got %b exp 0", snoop_err_o); end
        next_cycle();
        sb_valid_i = '0;
        sb_data_i  = '0;
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b1) begin errors++; $display("FAIL multi_err_set got %b exp 1", snoop_err_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b1) begin errors++; $display("FAIL multi_err_sticky got %b exp 1", snoop_err_o); end
        #1 nreset_i = 1'b0;
        #1;
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b exp 0", snoop_err_o); end
        checks++; if (sb_valid_o !== 4'b0000 || sb_last_rx_o !== 4'b0000) begin errors++; $display("FAIL rst_mid_sb got %b/%b exp 0000/0000", sb_valid_o, sb_last_rx_o); end
        checks++; if (resp_valid_o !== 1'b0 || resp_data_valid_o !== 1'b0 || mem_wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got %b/%b/%b exp 0/0/0", resp_valid_o, resp_data_valid_o, mem_wb_valid_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", req_ready_o); end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp got %b exp 0", resp_valid_o); end
        nreset_i = 1'b1;
        next_cycle();
        issue(2'd1, 32'h600, BUS_RD);
        @(negedge clk_i);
        checks++; if (req_ready_o !== 1'b1 || sb_tx_begin_o !== 1'b1 || sb_valid_o !== 4'b1101) begin errors++; $display("FAIL rst_after_accept got r%b t%b v%b exp r1 t1 v1101", req_ready_o, sb_tx_begin_o, sb_valid_o); end
        next_cycle();
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (resp_valid_o !== 1'b1 || resp_dirty_o !== 1'b0) begin errors++; $display("FAIL rst_after_resp got v%b d%b exp v1 d0", resp_valid_o, resp_dirty_o); end
        next_cycle();
    endtask

    // Data with no open transaction is an error.
    task automatic test_valid_outside();
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b0) begin errors++; $display("FAIL outside_err_before got %b exp 0", snoop_err_o); end
        next_cycle();
        sb_valid_i = 4'b0100;
        next_cycle();
        sb_valid_i = '0;
        @(negedge clk_i);
        checks++; if (snoop_err_o !== 1'b1) begin errors++; $display("FAIL outside_err_set got %b exp 1", snoop_err_o); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_no_hit();
        test_shared_hit();
        test_requester_mask();
        test_stall();
        test_writeback();
        test_back_to_back();
        test_multi_owner_and_reset();
        test_valid_outside();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
